commit_rob: RTL and testbench

- In-order reorder/commit buffer. Allocates the 4-bit dependency tags that dispatch writes into the register file.
- Collects execution results by tag, retires entries in program order, and drives the common data bus (cdb_*) that the register file consumes.
- Sits between issue/execute units and the register file. It is the producer end of the CDB protocol.

---
 rtl/commit_rob_if.sv | 32 +++
 rtl/commit_rob.sv | 103 ++++++++++
 tb/tb_commit_rob.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_rob_if.sv
// Dispatch, writeback and common-data-bus signals of the commit buffer.
// The slave modport is the buffer itself; the master modport is the issue/execute side.
interface commit_rob_if #(
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
);
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic [XLEN-1:0]  alloc_addr;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [XLEN-1:0]  wb_val;

  logic             cdb_active;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_val;
  logic [XLEN-1:0]  cdb_addr;
  logic [4:0]       cdb_rd_idx;

  modport master (
    output alloc_valid, alloc_rd, alloc_addr, wb_valid, wb_tag, wb_val,
    input  alloc_ready, alloc_tag, cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_rd_idx
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_addr, wb_valid, wb_tag, wb_val,
    output alloc_ready, alloc_tag, cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_rd_idx
  );
endinterface

// File: rtl/commit_rob.sv
// In-order reorder/commit buffer: hands out tags at dispatch, collects results by tag
// and retires one entry per cycle onto the common data bus in program order.
module commit_rob #(
  parameter int DEPTH = 15,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         predict_fail,
  output logic         empty,
  commit_rob_if.slave  rob
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  typedef logic [TAG_W-1:0] tag_t;

  logic [DEPTH-1:0] busy, done;
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  addr_q [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  tag_t             head, tail;
  logic [CNT_W-1:0] count;

  tag_t wb_idx;
  logic do_alloc, do_wb, do_commit, advance;

  function automatic tag_t next_ptr(input tag_t p);
    return (p == tag_t'(DEPTH - 1)) ? '0 : p + tag_t'(1);
  endfunction

  // Tag 0 means "no producer", so entry i is named by tag i+1.
  assign rob.alloc_ready = (count < CNT_W'(DEPTH));
  assign rob.alloc_tag   = tail + tag_t'(1);
  assign empty           = (count == '0);

  assign wb_idx    = rob.wb_tag - tag_t'(1);
  assign do_alloc  = rob.alloc_valid && rob.alloc_ready;
  assign do_wb     = rob.wb_valid && (rob.wb_tag != '0) && (rob.wb_tag <= tag_t'(DEPTH))
                     && busy[wb_idx];
  assign do_commit = busy[head] && done[head];
  assign advance   = rdy_in && !predict_fail;

  // NOTE: state registers use non-blocking assignments so every read in this block
  // sees the pre-edge value, which is what makes commit use done[] from before a
  // same-cycle writeback.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy           <= '0;
      done           <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      rob.cdb_active <= 1'b0;
      rob.cdb_tag    <= '0;
      rob.cdb_val    <= '0;
      rob.cdb_addr   <= '0;
      rob.cdb_rd_idx <= '0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        busy           <= '0;
        done           <= '0;
        head           <= '0;
        tail           <= '0;
        count          <= '0;
        rob.cdb_active <= 1'b0;
      end else begin
        if (do_alloc) begin
          busy[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tail       <= next_ptr(tail);
        end
        if (do_wb) done[wb_idx] <= 1'b1;
        // Commit is placed last so retiring the head wins over a writeback to it.
        if (do_commit) begin
          busy[head]     <= 1'b0;
          done[head]     <= 1'b0;
          head           <= next_ptr(head);
          rob.cdb_active <= 1'b1;
          rob.cdb_tag    <= head + tag_t'(1);
          rob.cdb_val    <= val_q[head];
          rob.cdb_addr   <= addr_q[head];
          rob.cdb_rd_idx <= rd_q[head];
        end else begin
          rob.cdb_active <= 1'b0;
        end
        count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
      end
    end
  end

  // NOTE: the payload array has no reset; busy/done alone decide whether an entry's
  // contents mean anything, and leaving the storage unreset lets it map to plain RAM.
  always_ff @(posedge clk_in) begin
    if (advance) begin
      if (do_alloc) begin
        rd_q[tail]   <= rob.alloc_rd;
        addr_q[tail] <= rob.alloc_addr;
      end
      if (do_wb) val_q[wb_idx] <= rob.wb_val;
    end
  end
endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: single commit, out-of-order results, full/wrap,
// flush, pause and asynchronous reset, each with hand-computed expectations.
module tb_commit_rob;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic rdy_in, predict_fail, empty;
  int vectors = 0;
  int miscompares = 0;

  commit_rob_if #(.TAG_W(4), .XLEN(32)) bus ();

  commit_rob dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .predict_fail (predict_fail),
    .empty        (empty),
    .rob          (bus)
  );

  always #5 clk_in = ~clk_in;

  // {active, tag, rd, val, addr}
  function automatic logic [73:0] cdb();
    return {bus.cdb_active, bus.cdb_tag, bus.cdb_rd_idx, bus.cdb_val, bus.cdb_addr};
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = '0;
    bus.alloc_addr  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_tag      = '0;
    bus.wb_val      = '0;
    predict_fail    = 1'b0;
    rdy_in          = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n_in = 1'b0;
    step();
    step();
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [31:0] addr);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = rd;
    bus.alloc_addr  = addr;
    step();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = tag;
    bus.wb_val   = val;
    step();
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.alloc_ready, bus.alloc_tag, empty} !== {1'b1, 4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_comb: got ready/tag/empty=%b/%0d/%b want 1/1/1",
               bus.alloc_ready, bus.alloc_tag, empty);
    end
    vectors++;
    if (cdb() !== 74'd0) begin
      miscompares++;
      $display("FAIL reset_cdb: got %h want 0", cdb());
    end
  endtask

  task automatic test_single_commit();
    do_reset();
    bus.alloc_valid = 1'b1;
    #1;
    vectors++;
    if (bus.alloc_tag !== 4'd1) begin
      miscompares++;
      $display("FAIL single_tag: got %0d want 1", bus.alloc_tag);
    end
    alloc(5'd5, 32'h100);
    vectors++;
    if (empty !== 1'b0) begin
      miscompares++;
      $display("FAIL single_not_empty: got %b want 0", empty);
    end
    wb(4'd1, 32'hDEADBEEF);
    vectors++;
    if (bus.cdb_active !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_bypass: got active %b want 0", bus.cdb_active);
    end
    step();
    vectors++;
    if (cdb() !== {1'b1, 4'd1, 5'd5, 32'hDEADBEEF, 32'h100}) begin
      miscompares++;
      $display("FAIL single_commit: got %h want %h", cdb(),
               {1'b1, 4'd1, 5'd5, 32'hDEADBEEF, 32'h100});
    end
    step();
    vectors++;
    if ({cdb(), empty} !== {1'b0, 4'd1, 5'd5, 32'hDEADBEEF, 32'h100, 1'b1}) begin
      miscompares++;
      $display("FAIL single_after: got cdb %h empty %b want active 0 fields held, empty 1",
               cdb(), empty);
    end
  endtask

  task automatic test_out_of_order();
    logic [73:0] exp;
    do_reset();
    for (int i = 1; i <= 3; i++) alloc(5'(i), 32'h10 + 32'(4 * (i - 1)));
    for (int t = 3; t >= 1; t--) begin
      wb(4'(t), 32'hA0 + 32'(t));
      vectors++;
      if (bus.cdb_active !== 1'b0) begin
        miscompares++;
        $display("FAIL ooo_wait_wb%0d: got active %b want 0", t, bus.cdb_active);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {1'b1, 4'(i), 5'(i), 32'hA0 + 32'(i), 32'h10 + 32'(4 * (i - 1))};
      vectors++;
      if (cdb() !== exp) begin
        miscompares++;
        $display("FAIL ooo_commit%0d: got %h want %h", i, cdb(), exp);
      end
    end
    step();
    vectors++;
    if ({bus.cdb_active, empty} !== 2'b01) begin
      miscompares++;
      $display("FAIL ooo_drained: got active/empty=%b/%b want 0/1", bus.cdb_active, empty);
    end
  endtask

  task automatic test_full_wrap();
    int bad_tags = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.alloc_valid = 1'b1;
      #1;
      if (bus.alloc_tag !== 4'(i + 1)) bad_tags++;
      alloc(5'(i), 32'(i * 4));
    end
    vectors++;
    if (bad_tags != 0) begin
      miscompares++;
      $display("FAIL full_tag_seq: got %0d wrong tags want 0", bad_tags);
    end
    vectors++;
    if (bus.alloc_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got %b want 0", bus.alloc_ready);
    end
    alloc(5'd31, 32'hFFF);
    wb(4'd1, 32'h55);
    // Request held across the commit edge must be refused: no same-cycle credit.
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd30;
    bus.alloc_addr  = 32'hEEE;
    step();
    bus.alloc_valid = 1'b0;
    vectors++;
    if (cdb() !== {1'b1, 4'd1, 5'd0, 32'h55, 32'h0}) begin
      miscompares++;
      $display("FAIL full_commit1: got %h want %h", cdb(), {1'b1, 4'd1, 5'd0, 32'h55, 32'h0});
    end
    vectors++;
    if ({bus.alloc_ready, bus.alloc_tag} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL full_wrap: got ready/tag=%b/%0d want 1/1", bus.alloc_ready, bus.alloc_tag);
    end
  endtask

  task automatic test_flush();
    int stray = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(5'(i), 32'h300 + 32'(i));
    wb(4'd2, 32'h2);
    wb(4'd3, 32'h3);
    predict_fail    = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd9;
    bus.wb_valid    = 1'b1;
    bus.wb_tag      = 4'd1;
    bus.wb_val      = 32'h1;
    step();
    idle();
    vectors++;
    if ({empty, bus.cdb_active, bus.alloc_tag} !== {1'b1, 1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL flush_state: got empty/active/tag=%b/%b/%0d want 1/0/1",
               empty, bus.cdb_active, bus.alloc_tag);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.cdb_active !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL flush_no_commit: got %0d stray commits want 0", stray);
    end
  endtask

  task automatic test_pause();
    logic [73:0] held;
    do_reset();
    for (int i = 1; i <= 3; i++) alloc(5'(i + 10), 32'h400 + 32'(i));
    wb(4'd1, 32'h11);
    wb(4'd2, 32'h22);
    step();
    held = {1'b1, 4'd2, 5'd12, 32'h22, 32'h402};
    vectors++;
    if (cdb() !== held) begin
      miscompares++;
      $display("FAIL pause_setup: got %h want %h", cdb(), held);
    end
    rdy_in          = 1'b0;
    bus.wb_valid    = 1'b1;
    bus.wb_tag      = 4'd3;
    bus.wb_val      = 32'h33;
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (cdb() !== held) begin
        miscompares++;
        $display("FAIL pause_hold%0d: got %h want %h", i, cdb(), held);
      end
    end
    idle();
    vectors++;
    if (bus.alloc_tag !== 4'd4) begin
      miscompares++;
      $display("FAIL pause_no_alloc: got tag %0d want 4", bus.alloc_tag);
    end
    step();
    vectors++;
    if (bus.cdb_active !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_no_dup: got active %b want 0", bus.cdb_active);
    end
    wb(4'd3, 32'h99);
    step();
    vectors++;
    if (cdb() !== {1'b1, 4'd3, 5'd13, 32'h99, 32'h403}) begin
      miscompares++;
      $display("FAIL pause_resume: got %h want %h", cdb(), {1'b1, 4'd3, 5'd13, 32'h99, 32'h403});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 1; i <= 6; i++) alloc(5'(i), 32'h500 + 32'(i));
    wb(4'd1, 32'h77);
    step();
    vectors++;
    if (bus.cdb_active !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_setup: got active %b want 1", bus.cdb_active);
    end
    #3;
    rst_n_in = 1'b0;
    #1;
    vectors++;
    if ({bus.cdb_active, empty, bus.alloc_tag} !== {1'b0, 1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL areset_immediate: got active/empty/tag=%b/%b/%0d want 0/1/1",
               bus.cdb_active, empty, bus.alloc_tag);
    end
    step();
    rst_n_in = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_single_commit();
    test_out_of_order();
    test_full_wrap();
    test_flush();
    test_pause();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
